// File: rtl/code_lock_ctrl.sv
// Code lock controller: debounced ENTER/CLOSE keys, parametrised secret code,
// failed-attempt counting, auto-relock timeout and lockout after repeated failures.

// Single-key debouncer: 2-flop synchroniser, stability counter, falling-edge press pulse.
module code_lock_deb #(
    parameter int DEB_W = 18
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    logic             s1;
    logic             s2;
    logic             stable;
    logic             stable_prev;
    logic [DEB_W-1:0] cnt;

    // Synchronise the raw key into the clock domain; idle level is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
        end else begin
            s1 <= key_n;
            s2 <= s1;
        end
    end

    // Accept a new level only after it has differed from stable for 2^DEB_W cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable      <= 1'b1;
            stable_prev <= 1'b1;
            cnt         <= '0;
        end else begin
            stable_prev <= stable;
            if (s2 != stable) begin
                if (&cnt) begin
                    stable <= s2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    // One-cycle pulse on each accepted high-to-low transition.
    assign press = stable_prev & ~stable;

endmodule

module code_lock_ctrl #(
    parameter int                  CODE_W       = 4,
    parameter logic [CODE_W-1:0]   CODE         = 4'b0111,
    parameter int                  DEB_W        = 18,
    parameter int                  MAX_TRIES    = 3,
    parameter logic [23:0]         OPEN_CYCLES  = 24'd12_000_000,
    parameter logic [23:0]         ALARM_CYCLES = 24'd6_000_000,
    parameter logic [27:0]         LOCK_CYCLES  = 28'd120_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] code,
    input  logic [1:0]        key_n,
    output logic              led_open_n,
    output logic              led_alarm_n,
    output logic              led_lock_n,
    output logic [3:0]        fail_cnt,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OPEN    = 2'd1,
        ST_ALARM   = 2'd2,
        ST_LOCKOUT = 2'd3
    } st_t;

    // Timer only ever needs to reach the largest *_CYCLES value minus one.
    localparam int unsigned OPEN_I  = 32'(OPEN_CYCLES);
    localparam int unsigned ALARM_I = 32'(ALARM_CYCLES);
    localparam int unsigned LOCK_I  = 32'(LOCK_CYCLES);
    localparam int unsigned MAX_OA  = (OPEN_I > ALARM_I) ? OPEN_I : ALARM_I;
    localparam int unsigned MAX_I   = (MAX_OA > LOCK_I) ? MAX_OA : LOCK_I;
    localparam int          TW      = (MAX_I < 2) ? 1 : $clog2(MAX_I);

    localparam logic [TW-1:0] OPEN_LAST  = TW'(OPEN_I - 1);
    localparam logic [TW-1:0] ALARM_LAST = TW'(ALARM_I - 1);
    localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCK_I - 1);
    localparam logic [3:0]    MAX_T      = 4'(MAX_TRIES);

    logic [1:0]    press;
    logic          enter_p;
    logic          close_p;
    st_t           st_q;
    st_t           st_nxt;
    logic [3:0]    fail_nxt;
    logic [TW-1:0] timer;
    logic          led_open_nxt;
    logic          led_alarm_nxt;
    logic          led_lock_nxt;

    // One identical debouncer per key: [0]=ENTER, [1]=CLOSE.
    for (genvar k = 0; k < 2; k++) begin : g_deb
        code_lock_deb #(.DEB_W(DEB_W)) u_deb (
            .clk   (clk),
            .rst   (rst),
            .key_n (key_n[k]),
            .press (press[k])
        );
    end

    assign enter_p = press[0];
    assign close_p = press[1];

    // State, attempt counter, shared timer and LED registers all move on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q        <= ST_IDLE;
            fail_cnt    <= 4'd0;
            timer       <= '0;
            led_open_n  <= 1'b1;
            led_alarm_n <= 1'b1;
            led_lock_n  <= 1'b1;
        end else begin
            st_q        <= st_nxt;
            fail_cnt    <= fail_nxt;
            timer       <= (st_nxt != st_q) ? '0 : timer + 1'b1;
            led_open_n  <= led_open_nxt;
            led_alarm_n <= led_alarm_nxt;
            led_lock_n  <= led_lock_nxt;
        end
    end

    // Next state and next failure count; CLOSE is irrelevant in IDLE and wins in OPEN.
    always_comb begin
        st_nxt   = st_q;
        fail_nxt = fail_cnt;
        case (st_q)
            ST_IDLE: begin
                if (enter_p) begin
                    if (code == CODE) begin
                        st_nxt   = ST_OPEN;
                        fail_nxt = 4'd0;
                    end else begin
                        fail_nxt = (fail_cnt < MAX_T) ? fail_cnt + 4'd1 : fail_cnt;
                        st_nxt   = (fail_nxt == MAX_T) ? ST_LOCKOUT : ST_ALARM;
                    end
                end
            end
            ST_OPEN: begin
                if (close_p || (timer == OPEN_LAST)) st_nxt = ST_IDLE;
            end
            ST_ALARM: begin
                if (timer == ALARM_LAST) st_nxt = ST_IDLE;
            end
            ST_LOCKOUT: begin
                if (timer == LOCK_LAST) begin
                    st_nxt   = ST_IDLE;
                    fail_nxt = 4'd0;
                end
            end
            default: st_nxt = ST_IDLE;
        endcase
    end

    // Active-low LED values derived from the upcoming state so they register with it.
    always_comb begin
        led_open_nxt  = (st_nxt != ST_OPEN);
        led_alarm_nxt = !((st_nxt == ST_ALARM) || (st_nxt == ST_LOCKOUT));
        led_lock_nxt  = (st_nxt != ST_LOCKOUT);
    end

    assign state = st_q;

endmodule
